// File: rtl/interrupt_ack_pkg.sv
// Shared encodings and helpers for the interrupt-acknowledge sequencer.
package interrupt_ack_pkg;

  typedef enum logic [2:0] {
    CTL_READY = 3'b000,
    ACK1      = 3'b001,
    ACK2      = 3'b010,
    ACK3      = 3'b011,
    POLL      = 3'b100
  } ctl_state_e;

  // Level reported when an acknowledge finds no pending request.
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  // Binary index of the set bit; the lowest set bit wins on a malformed input.
  function automatic logic [2:0] one_hot_to_level(input logic [7:0] one_hot);
    logic [2:0] level;
    level = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (one_hot[i]) level = 3'(i);
    end
    return level;
  endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_sync_edge.sv
// Multi-stage synchronizer followed by a previous-value flop, yielding edge strobes.
module sync_edge_detect #(
  parameter int unsigned SyncStages = 2,
  parameter bit          ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  prev_q, prev_d;

  // Shift the pin into the chain; prev trails the synchronized output by one cycle.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], async_i};
    prev_d = sync_q[SyncStages-1];
  end

  // Chain and history flops preset to the pin's idle level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SyncStages{ResetValue}};
      prev_q <= ResetValue;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = ~prev_q & sync_q[SyncStages-1];
  assign fall_o = prev_q & ~sync_q[SyncStages-1];

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// Sequences INTA pulse trains and poll reads, capturing the serviced level.
module interrupt_ack_sequencer
  import interrupt_ack_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       interrupt_acknowledge_n,
  input  logic       read,
  input  logic       u8086_or_mcs80_config,
  input  logic [7:0] interrupt,
  input  logic       poll_command,
  input  logic       write_initial_command_word_1,
  output logic [2:0] control_state,
  output logic [2:0] interrupt_when_ack1,
  output logic       interrupt_valid,
  output logic       latch_in_service,
  output logic       freeze,
  output logic       end_of_acknowledge_sequence,
  output logic       end_of_poll_command
);

  logic inta_rise, inta_fall, read_rise, read_fall;

  ctl_state_e state_q, state_d;
  logic [2:0] level_q, level_d;
  logic       valid_q, valid_d;
  logic       mode_q, mode_d;
  logic       latch_q, latch_d;
  logic       freeze_q, freeze_d;
  logic       eoa_q, eoa_d;
  logic       eop_q, eop_d;

  logic [2:0] req_level;
  logic       req_valid;

  sync_edge_detect #(
    .SyncStages (SYNC_STAGES),
    .ResetValue (1'b1)
  ) u_inta_edge (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .async_i(interrupt_acknowledge_n),
    .rise_o (inta_rise),
    .fall_o (inta_fall)
  );

  sync_edge_detect #(
    .SyncStages (SYNC_STAGES),
    .ResetValue (1'b0)
  ) u_read_edge (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .async_i(read),
    .rise_o (read_rise),
    .fall_o (read_fall)
  );

  // Level/valid that a capture would record this cycle.
  always_comb begin
    req_valid = (interrupt != 8'd0);
    req_level = req_valid ? one_hot_to_level(interrupt) : SPURIOUS_LEVEL;
  end

  // Next-state, capture and strobe decode; ICW1 overrides everything.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    valid_d = valid_q;
    mode_d  = mode_q;
    latch_d = 1'b0;
    eoa_d   = 1'b0;
    eop_d   = 1'b0;

    if (write_initial_command_word_1) begin
      state_d = CTL_READY;
      level_d = 3'd0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        CTL_READY: begin
          if (inta_fall) begin
            state_d = ACK1;
            level_d = req_level;
            valid_d = req_valid;
            latch_d = req_valid;
            mode_d  = u8086_or_mcs80_config;
          end else if (poll_command) begin
            state_d = POLL;
          end
        end
        ACK1: begin
          if (inta_fall) state_d = ACK2;
        end
        ACK2: begin
          if (mode_q) begin
            if (inta_rise) begin
              eoa_d   = 1'b1;
              state_d = CTL_READY;
            end
          end else if (inta_fall) begin
            state_d = ACK3;
          end
        end
        ACK3: begin
          if (inta_rise) begin
            eoa_d   = 1'b1;
            state_d = CTL_READY;
          end
        end
        POLL: begin
          if (read_rise) begin
            level_d = req_level;
            valid_d = req_valid;
            latch_d = req_valid;
          end else if (read_fall) begin
            eop_d   = 1'b1;
            state_d = CTL_READY;
          end
        end
        default: state_d = CTL_READY;
      endcase
    end

    freeze_d = (state_d != CTL_READY);
  end

  // All outputs registered so downstream sees glitch-free levels and strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= CTL_READY;
      level_q  <= 3'd0;
      valid_q  <= 1'b0;
      mode_q   <= 1'b0;
      latch_q  <= 1'b0;
      freeze_q <= 1'b0;
      eoa_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      mode_q   <= mode_d;
      latch_q  <= latch_d;
      freeze_q <= freeze_d;
      eoa_q    <= eoa_d;
      eop_q    <= eop_d;
    end
  end

  assign control_state               = state_q;
  assign interrupt_when_ack1         = level_q;
  assign interrupt_valid             = valid_q;
  assign latch_in_service            = latch_q;
  assign freeze                      = freeze_q;
  assign end_of_acknowledge_sequence = eoa_q;
  assign end_of_poll_command         = eop_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Bench for interrupt_ack_sequencer: vector table, corner sequences, random traffic.
module tb_interrupt_ack_sequencer;

  logic       clock;
  logic       reset_n;
  logic       inta_n;
  logic       rd;
  logic       mode;
  logic [7:0] irq;
  logic       poll_cmd;
  logic       icw1;
  logic [2:0] control_state;
  logic [2:0] level;
  logic       valid;
  logic       latch;
  logic       freeze;
  logic       eoa;
  logic       eop;

  int total = 0;
  int bad   = 0;

  interrupt_ack_sequencer #(
    .SYNC_STAGES(2)
  ) dut (
    .clock                       (clock),
    .reset_n                     (reset_n),
    .interrupt_acknowledge_n     (inta_n),
    .read                        (rd),
    .u8086_or_mcs80_config       (mode),
    .interrupt                   (irq),
    .poll_command                (poll_cmd),
    .write_initial_command_word_1(icw1),
    .control_state               (control_state),
    .interrupt_when_ack1         (level),
    .interrupt_valid             (valid),
    .latch_in_service            (latch),
    .freeze                      (freeze),
    .end_of_acknowledge_sequence (eoa),
    .end_of_poll_command         (eop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observer: pulse counts, pulse-width and freeze violations, state trace (octal digits).
  int          latch_cnt  = 0;
  int          eoa_cnt    = 0;
  int          eop_cnt    = 0;
  int          width_err  = 0;
  int          freeze_err = 0;
  logic        p_latch    = 1'b0;
  logic        p_eoa      = 1'b0;
  logic        p_eop      = 1'b0;
  logic [2:0]  last_st    = 3'd0;
  logic [14:0] trace      = 15'd0;

  always @(negedge clock) begin
    p_latch <= latch;
    p_eoa   <= eoa;
    p_eop   <= eop;
    if (latch) latch_cnt <= latch_cnt + 1;
    if (eoa) eoa_cnt <= eoa_cnt + 1;
    if (eop) eop_cnt <= eop_cnt + 1;
    if ((latch && p_latch) || (eoa && p_eoa) || (eop && p_eop)) width_err <= width_err + 1;
    if ((freeze !== (control_state != 3'd0)) || (control_state > 3'd4))
      freeze_err <= freeze_err + 1;
    if (control_state != last_st) begin
      last_st <= control_state;
      trace   <= {trace[11:0], control_state};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input int lo, input int hi);
    inta_n = 1'b0;
    cycles(lo);
    inta_n = 1'b1;
    cycles(hi);
  endtask

  // Reference: spurious IR7 when nothing pending, else index of lowest set bit.
  function automatic logic [2:0] ref_level(input logic [7:0] v);
    logic [7:0] low;
    if (v == 8'd0) return 3'd7;
    low = v & (~v + 8'd1);
    return 3'($clog2(low));
  endfunction

  typedef struct {
    bit          mode;
    logic [7:0]  irq;
    logic [2:0]  lvl;
    bit          vld;
    int          latches;
    logic [14:0] trace;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int l0, e0, p0;
    inta_n = 1'b1; rd = 1'b0; mode = 1'b0; irq = 8'd0; poll_cmd = 1'b0; icw1 = 1'b0;
    reset_n = 1'b0;
    cycles(3);
    check("reset_state", control_state, 0);
    check("reset_level", level, 0);
    check("reset_valid", valid, 0);
    check("reset_pulses", {latch, freeze, eoa, eop}, 0);
    reset_n = 1'b1;
    cycles(2);

    vecs[0] = '{1'b1, 8'b0001_0000, 3'd4, 1'b1, 1, 15'o0120};
    vecs[1] = '{1'b0, 8'b1000_0000, 3'd7, 1'b1, 1, 15'o01230};
    vecs[2] = '{1'b1, 8'b0000_0000, 3'd7, 1'b0, 0, 15'o0120};
    vecs[3] = '{1'b0, 8'b0000_0001, 3'd0, 1'b1, 1, 15'o01230};
    vecs[4] = '{1'b1, 8'b0010_1000, 3'd3, 1'b1, 1, 15'o0120};

    // Latency: pin falls before edge 1, state moves at edge 3.
    mode = 1'b1; irq = 8'b0000_0010;
    inta_n = 1'b0;
    cycles(2);
    check("latency_edge2", control_state, 0);
    cycles(1);
    check("latency_edge3", control_state, 1);
    cycles(1);
    inta_n = 1'b1;
    cycles(4);
    pulse(4, 4);
    check("latency_seq_level", level, 1);
    cycles(2);

    // Table-driven acknowledge sequences.
    for (int i = 0; i < 5; i++) begin
      int n;
      mode = vecs[i].mode; irq = vecs[i].irq;
      l0 = latch_cnt; e0 = eoa_cnt;
      n = vecs[i].mode ? 2 : 3;
      for (int k = 0; k < n; k++) begin
        pulse(4, 4);
        if (k == 0) irq = ~vecs[i].irq;
        if (k == 1 && n == 3) check($sformatf("v%0d_no_early_eoa", i), eoa_cnt - e0, 0);
      end
      check($sformatf("v%0d_level", i), level, vecs[i].lvl);
      check($sformatf("v%0d_valid", i), valid, vecs[i].vld);
      check($sformatf("v%0d_latch", i), latch_cnt - l0, vecs[i].latches);
      check($sformatf("v%0d_eoa", i), eoa_cnt - e0, 1);
      check($sformatf("v%0d_trace", i), trace & (vecs[i].mode ? 15'o07777 : 15'o77777),
            vecs[i].trace);
      cycles(2);
    end

    // Poll read.
    irq = 8'b0000_0100;
    l0 = latch_cnt; p0 = eop_cnt;
    poll_cmd = 1'b1; cycles(1); poll_cmd = 1'b0;
    check("poll_state", control_state, 4);
    check("poll_freeze", freeze, 1);
    rd = 1'b1; cycles(4);
    check("poll_level", level, 2);
    check("poll_latch", latch_cnt - l0, 1);
    check("poll_no_early_eop", eop_cnt - p0, 0);
    rd = 1'b0; cycles(4);
    check("poll_eop", eop_cnt - p0, 1);
    check("poll_done_state", control_state, 0);
    cycles(2);

    // ICW1 abort in ACK2.
    mode = 1'b1; irq = 8'b0001_0000; e0 = eoa_cnt;
    pulse(4, 4);
    inta_n = 1'b0; cycles(4);
    check("icw1_pre_state", control_state, 2);
    icw1 = 1'b1; cycles(1); icw1 = 1'b0;
    check("icw1_state", control_state, 0);
    check("icw1_freeze", freeze, 0);
    check("icw1_level", level, 0);
    check("icw1_valid", valid, 0);
    inta_n = 1'b1; cycles(5);
    check("icw1_no_eoa", eoa_cnt - e0, 0);

    // Mode input toggled mid-sequence.
    mode = 1'b1; irq = 8'b0000_1000; e0 = eoa_cnt;
    inta_n = 1'b0; cycles(4);
    mode = 1'b0;
    inta_n = 1'b1; cycles(4);
    pulse(4, 4);
    check("mode_toggle_eoa", eoa_cnt - e0, 1);
    check("mode_toggle_state", control_state, 0);
    cycles(2);

    // Reset during ACK3.
    mode = 1'b0; irq = 8'b0010_0000; e0 = eoa_cnt;
    pulse(4, 4); pulse(4, 4);
    inta_n = 1'b0; cycles(4);
    check("rst_pre_state", control_state, 3);
    reset_n = 1'b0; #1;
    check("rst_state", control_state, 0);
    check("rst_outs", {level, valid, latch, freeze, eoa, eop}, 0);
    inta_n = 1'b1; cycles(3);
    reset_n = 1'b1; cycles(4);
    check("rst_no_eoa", eoa_cnt - e0, 0);
    check("rst_idle", control_state, 0);

    // Randomized acknowledge/poll traffic vs the reference rules.
    for (int it = 0; it < 30; it++) begin
      logic [7:0] v;
      logic [2:0] exp_l;
      bit         exp_v;
      int         sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       v = 8'd0;
        3:       v = 8'($urandom);
        default: v = 8'd1 << $urandom_range(0, 7);
      endcase
      exp_l = ref_level(v);
      exp_v = (v != 8'd0);
      irq = v;
      l0 = latch_cnt; e0 = eoa_cnt; p0 = eop_cnt;
      if ($urandom_range(0, 2) == 0) begin
        poll_cmd = 1'b1; cycles(1); poll_cmd = 1'b0;
        rd = 1'b1; cycles($urandom_range(3, 6));
        irq = 8'($urandom);
        rd = 1'b0; cycles(5);
        check("rnd_poll_eop", eop_cnt - p0, 1);
        check("rnd_poll_eoa", eoa_cnt - e0, 0);
      end else begin
        int n;
        mode = 1'($urandom);
        n = mode ? 2 : 3;
        for (int k = 0; k < n; k++) begin
          inta_n = 1'b0; cycles($urandom_range(3, 6));
          if (k == 0) begin
            irq  = 8'($urandom);
            mode = 1'($urandom);
          end
          inta_n = 1'b1; cycles($urandom_range(4, 6));
        end
        check("rnd_ack_eoa", eoa_cnt - e0, 1);
      end
      check("rnd_level", level, exp_l);
      check("rnd_valid", valid, exp_v);
      check("rnd_latch", latch_cnt - l0, exp_v ? 1 : 0);
      check("rnd_state", control_state, 0);
      cycles(1);
    end

    check("pulse_width", width_err, 0);
    check("freeze_track", freeze_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
